// File: rtl/fake_bus_mem_pkg.sv
// Shared CPU bus definitions: word/mask types, byte-index shift and wait-state FSM states.
package cpu_defs;

    typedef logic [31:0] Word_t;
    typedef logic [3:0]  ByteMask_t;

    localparam int unsigned ADDR_LSB = 2;

    typedef enum logic {
        WS_IDLE,
        WS_SERVE
    } ws_state_e;

endpackage

// File: rtl/fake_bus_mem_if.sv
// CPU bus bundle with master (CPU) and slave (memory) views.
interface Bus_if;
    import cpu_defs::*;

    Word_t     address;
    logic      read;
    logic      write;
    ByteMask_t mask;
    Word_t     wdata;
    Word_t     rdata;
    logic      stall;

    modport master (output address, read, write, mask, wdata, input rdata, stall);
    modport slave  (input address, read, write, mask, wdata, output rdata, stall);
endinterface

// File: rtl/fake_bus_mem_merge.sv
// Byte-lane merge: mask bit i selects new_i byte i, otherwise old_i byte i.
module bus_byte_merge
    import cpu_defs::*;
(
    input  Word_t     old_i,
    input  Word_t     new_i,
    input  ByteMask_t mask_i,
    output Word_t     merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int unsigned i = 0; i < 4; i++) begin
            if (mask_i[i]) begin
                merged_o[8*i +: 8] = new_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/fake_bus_mem.sv
// Simulation memory slave: zero-wait instruction ROM plus byte-masked data RAM.
// Optional one-cycle data wait state per access when FAKE_BUS_WAIT_STATE_EN is defined.
module fake_bus_mem
    import cpu_defs::*;
#(
    parameter int unsigned INST_WORDS = 65536,
    parameter int unsigned DATA_WORDS = 16384,
    parameter int unsigned ADDR_LSB   = cpu_defs::ADDR_LSB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_address,
    input  logic        inst_read,
    output logic [31:0] inst_rdata,
    output logic        inst_stall,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_mask,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_stall,
    output logic [31:0] data_w
);

    localparam int unsigned IW = $clog2(INST_WORDS);
    localparam int unsigned DW = $clog2(DATA_WORDS);

    Word_t inst_mem [INST_WORDS];
    Word_t inst_ram [DATA_WORDS];

    Bus_if data_bus ();

    logic [IW-1:0] inst_idx;
    logic [DW-1:0] data_idx;
    Word_t         old_word;
    Word_t         merged;
    logic          stall;
    logic          write_en;

    assign data_bus.address = data_address;
    assign data_bus.read    = data_read;
    assign data_bus.write   = data_write;
    assign data_bus.mask    = data_mask;
    assign data_bus.wdata   = data_wdata;

    // Upper address bits alias and lane bits are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_address[ADDR_LSB-1:0], inst_address[31:ADDR_LSB+IW],
                                data_bus.address[ADDR_LSB-1:0], data_bus.address[31:ADDR_LSB+DW]};

    assign inst_idx   = inst_address[ADDR_LSB +: IW];
    assign inst_rdata = (inst_read && !rst) ? inst_mem[inst_idx] : '0;
    assign inst_stall = 1'b0;

    assign data_idx = data_bus.address[ADDR_LSB +: DW];
    assign old_word = inst_ram[data_idx];

    bus_byte_merge u_merge (
        .old_i    (old_word),
        .new_i    (data_bus.wdata),
        .mask_i   (data_bus.mask),
        .merged_o (merged)
    );

`ifdef FAKE_BUS_WAIT_STATE_EN
    ws_state_e ws_q, ws_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            ws_q <= WS_IDLE;
        end else begin
            ws_q <= ws_d;
        end
    end

    // First cycle of every access stalls; the second is serviced and returns to idle.
    always_comb begin
        ws_d  = ws_q;
        stall = 1'b0;
        case (ws_q)
            WS_IDLE: begin
                if (!rst && (data_bus.read || data_bus.write)) begin
                    stall = 1'b1;
                    ws_d  = WS_SERVE;
                end
            end
            WS_SERVE: ws_d = WS_IDLE;
            default:  ws_d = WS_IDLE;
        endcase
    end
`else
    assign stall = 1'b0;
`endif

    assign data_bus.stall = stall;
    assign data_bus.rdata = (data_bus.read && !rst && !stall) ? old_word : '0;

    assign data_rdata = data_bus.rdata;
    assign data_stall = data_bus.stall;
    assign data_w     = rst ? '0 : merged;

    assign write_en = data_bus.write && !rst && !stall;

    always_ff @(posedge clk) begin
        if (write_en) begin
            inst_ram[data_idx] <= merged;
        end
    end

endmodule

// File: tb/tb_fake_bus_mem.sv
// Directed bench for fake_bus_mem (default zero-wait build) with a queue scoreboard.
module tb_fake_bus_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_address;
    logic        inst_read;
    logic [31:0] inst_rdata;
    logic        inst_stall;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_mask;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_stall;
    logic [31:0] data_w;

    int tests_run = 0;
    int tests_failed = 0;

    typedef enum int {SEL_INST_RDATA, SEL_INST_STALL, SEL_DATA_RDATA, SEL_DATA_STALL, SEL_DATA_W} sel_e;

    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fake_bus_mem dut (
        .clk          (clk),
        .rst          (rst),
        .inst_address (inst_address),
        .inst_read    (inst_read),
        .inst_rdata   (inst_rdata),
        .inst_stall   (inst_stall),
        .data_address (data_address),
        .data_read    (data_read),
        .data_write   (data_write),
        .data_mask    (data_mask),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_stall   (data_stall),
        .data_w       (data_w)
    );

    task automatic expect_val(input string tag, input sel_e sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [31:0] ia, input logic ir,
                         input logic [31:0] da, input logic dr, input logic dwr,
                         input logic [3:0] m, input logic [31:0] wd);
        @(posedge clk);
        #2;
        rst          = r;
        inst_address = ia;
        inst_read    = ir;
        data_address = da;
        data_read    = dr;
        data_write   = dwr;
        data_mask    = m;
        data_wdata   = wd;
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        #3;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                SEL_INST_RDATA: obs = inst_rdata;
                SEL_INST_STALL: obs = {31'd0, inst_stall};
                SEL_DATA_RDATA: obs = data_rdata;
                SEL_DATA_STALL: obs = {31'd0, data_stall};
                default:        obs = data_w;
            endcase
            tests_run++;
            assert (obs === e.exp) else begin
                tests_failed++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    end

    initial begin
        rst = 1'b1; inst_address = '0; inst_read = 1'b0; data_address = '0;
        data_read = 1'b0; data_write = 1'b0; data_mask = '0; data_wdata = '0;
        for (int unsigned i = 0; i < 65536; i++) dut.inst_mem[i] = '0;
        for (int unsigned i = 0; i < 16384; i++) dut.inst_ram[i] = '0;
        dut.inst_mem[0] = 32'h3401_1234;
        dut.inst_ram[1] = 32'hAABB_CCDD;
        dut.inst_ram[2] = 32'h0BAD_0BAD;

        // Reset with an attempted full-word write to word 2: everything reads 0, no write.
        drive(1'b1, 32'h0, 1'b1, 32'h8, 1'b1, 1'b1, 4'hF, 32'hFFFF_FFFF);
        expect_val("rst_inst_rdata", SEL_INST_RDATA, 32'h0);
        expect_val("rst_inst_stall", SEL_INST_STALL, 32'h0);
        expect_val("rst_data_rdata", SEL_DATA_RDATA, 32'h0);
        expect_val("rst_data_stall", SEL_DATA_STALL, 32'h0);
        expect_val("rst_data_w",     SEL_DATA_W,     32'h0);
        check_all();

        drive(1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 1'b0, 4'h0, 32'h0);
        expect_val("rst_preserve_w2", SEL_DATA_RDATA, 32'h0BAD_0BAD);
        expect_val("inst_fetch0",     SEL_INST_RDATA, 32'h3401_1234);
        expect_val("data_stall_idle", SEL_DATA_STALL, 32'h0);
        check_all();

        drive(1'b0, 32'h0, 1'b0, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0);
        expect_val("inst_read_low", SEL_INST_RDATA, 32'h0);
        expect_val("data_read_low", SEL_DATA_RDATA, 32'h0);
        check_all();

        drive(1'b0, 32'h0004_0003, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
        expect_val("inst_alias_wrap", SEL_INST_RDATA, 32'h3401_1234);
        check_all();

        // Byte-lane store with concurrent read: data_w merged, read sees old word.
        drive(1'b0, 32'h0, 1'b0, 32'h4, 1'b1, 1'b1, 4'b0010, 32'h0000_EE00);
        expect_val("merge_data_w",   SEL_DATA_W,     32'hAABB_EEDD);
        expect_val("merge_old_read", SEL_DATA_RDATA, 32'hAABB_CCDD);
        check_all();

        drive(1'b0, 32'h0, 1'b0, 32'h4, 1'b1, 1'b0, 4'h0, 32'h0);
        expect_val("merge_committed", SEL_DATA_RDATA, 32'hAABB_EEDD);
        check_all();

        drive(1'b0, 32'h0, 1'b0, 32'h8, 1'b1, 1'b1, 4'hF, 32'h1234_5678);
        expect_val("full_data_w",   SEL_DATA_W,     32'h1234_5678);
        expect_val("full_old_read", SEL_DATA_RDATA, 32'h0BAD_0BAD);
        check_all();

        drive(1'b0, 32'h0, 1'b0, 32'h8, 1'b1, 1'b0, 4'h0, 32'h0);
        expect_val("full_committed", SEL_DATA_RDATA, 32'h1234_5678);
        check_all();

        drive(1'b0, 32'h0, 1'b0, 32'h0001_0008, 1'b1, 1'b0, 4'h0, 32'h0);
        expect_val("data_alias_wrap", SEL_DATA_RDATA, 32'h1234_5678);
        check_all();

        drive(1'b0, 32'h0, 1'b0, 32'hB, 1'b1, 1'b0, 4'h0, 32'h0);
        expect_val("data_unaligned", SEL_DATA_RDATA, 32'h1234_5678);
        check_all();

        // Empty mask writes back the unchanged word.
        drive(1'b0, 32'h0, 1'b0, 32'h4, 1'b0, 1'b1, 4'h0, 32'hFFFF_FFFF);
        expect_val("mask0_data_w", SEL_DATA_W, 32'hAABB_EEDD);
        check_all();

        drive(1'b0, 32'h0, 1'b0, 32'h4, 1'b1, 1'b0, 4'h0, 32'h0);
        expect_val("mask0_unchanged", SEL_DATA_RDATA, 32'hAABB_EEDD);
        check_all();

        drive(1'b1, 32'h0, 1'b1, 32'h4, 1'b1, 1'b1, 4'hF, 32'h0);
        expect_val("rst2_data_rdata", SEL_DATA_RDATA, 32'h0);
        expect_val("rst2_data_w",     SEL_DATA_W,     32'h0);
        expect_val("rst2_inst_rdata", SEL_INST_RDATA, 32'h0);
        check_all();

        drive(1'b0, 32'h0, 1'b0, 32'h4, 1'b1, 1'b0, 4'h0, 32'h0);
        expect_val("rst2_write_blocked", SEL_DATA_RDATA, 32'hAABB_EEDD);
        check_all();

        drive(1'b0, 32'h0, 1'b0, 32'h8, 1'b1, 1'b0, 4'h0, 32'h0);
        expect_val("rst2_preserve_w2", SEL_DATA_RDATA, 32'h1234_5678);
        check_all();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
